// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - single-port arbiter for unified instruction/data memory
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req/if_addr             fetch request in; if_rdata/if_done result out
//   d_read/d_write/d_addr/d_wdata/d_size/d_unsigned   data request in
//   d_rdata/d_done/d_misalign  data result out
//   stall                      pipeline hold
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be   external memory request
//   mem_ack/mem_rdata          external memory completion and read data
module unified_mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_misalign,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

    state_t      state, state_nx;
    logic        d_served, if_served;
    logic [31:0] d_rdata_q, if_rdata_q;
    logic        d_pend, if_pend, misaligned;
    logic        is_byte, is_half, is_word;
    logic        issue_d, issue_if, d_ack, if_ack;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc, lane, load_ext;
    logic [4:0]  lane_shift;

    assign is_byte = (d_size == 2'b00);
    assign is_half = (d_size == 2'b01);
    assign is_word = d_size[1];

    assign d_pend     = (d_read | d_write) & ~d_served;
    assign if_pend    = if_req & ~if_served;
    assign misaligned = (is_half & d_addr[0]) | (is_word & (d_addr[1:0] != 2'b00));

    assign issue_d  = (state == IDLE) & d_pend & ~misaligned;
    assign issue_if = (state == IDLE) & ~d_pend & if_pend;
    assign d_ack    = (state == DATA) & mem_ack;
    assign if_ack   = (state == FETCH) & mem_ack;

    assign d_misalign = (state == IDLE) & d_pend & misaligned;
    assign d_done     = d_misalign | d_ack;
    assign if_done    = if_ack;

    assign stall = ~((~(d_read | d_write) | d_served | d_done) &
                     (~if_req | if_served | if_done));

    // Byte enables and lane-replicated store data.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = d_wdata;
        if (is_byte) begin
            be_calc    = 4'b0001 << d_addr[1:0];
            wdata_calc = {4{d_wdata[7:0]}};
        end else if (is_half) begin
            be_calc    = 4'b0011 << {d_addr[1], 1'b0};
            wdata_calc = {2{d_wdata[15:0]}};
        end
    end

    // Shift the addressed lane down to bit 0, then extend.
    always_comb begin
        lane_shift = 5'd0;
        if (is_byte)
            lane_shift = {d_addr[1:0], 3'b000};
        else if (is_half)
            lane_shift = {d_addr[1], 4'b0000};
    end

    assign lane = mem_rdata >> lane_shift;

    always_comb begin
        load_ext = lane;
        if (is_byte)
            load_ext = {{24{~d_unsigned & lane[7]}}, lane[7:0]};
        else if (is_half)
            load_ext = {{16{~d_unsigned & lane[15]}}, lane[15:0]};
    end

    // The acknowledged result is visible combinationally in the ack cycle,
    // then held from the register until the pipeline advances.
    assign d_rdata  = d_ack  ? load_ext  : d_rdata_q;
    assign if_rdata = if_ack ? mem_rdata : if_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (issue_d)
                    state_nx = DATA;
                else if (issue_if)
                    state_nx = FETCH;
            end
            DATA:    if (mem_ack) state_nx = IDLE;
            FETCH:   if (mem_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_be    <= 4'b0000;
        end else if (issue_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_write;
            mem_addr  <= d_addr & 32'hFFFF_FFFC;
            mem_wdata <= wdata_calc;
            mem_be    <= be_calc;
        end else if (issue_if) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr & 32'hFFFF_FFFC;
            mem_wdata <= 32'h0;
            mem_be    <= 4'b1111;
        end else if (d_ack | if_ack) begin
            mem_req   <= 1'b0;
        end
    end

    // Served flags keep a completed access from being reissued while the
    // other port is still holding the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_served   <= 1'b0;
            if_served  <= 1'b0;
            d_rdata_q  <= 32'h0;
            if_rdata_q <= 32'h0;
        end else begin
            if (!stall) begin
                d_served  <= 1'b0;
                if_served <= 1'b0;
            end else begin
                if (d_done)
                    d_served <= 1'b1;
                if (if_done)
                    if_served <= 1'b1;
            end
            if (d_ack)
                d_rdata_q <= load_ext;
            if (if_ack)
                if_rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - scoreboard bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_read, d_write;
    logic [31:0] d_addr, d_wdata;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] d_rdata;
    logic        d_done, d_misalign, stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic        chk_be;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } req_t;

    req_t        req_q[$];
    logic [31:0] exp_d_q[$];
    logic [31:0] exp_if_q[$];

    always #5 clk = ~clk;

    unified_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_unsigned(d_unsigned), .d_rdata(d_rdata),
        .d_done(d_done), .d_misalign(d_misalign), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic clear_inputs();
        if_req = 0; if_addr = 0;
        d_read = 0; d_write = 0; d_addr = 0; d_wdata = 0;
        d_size = 0; d_unsigned = 0;
    endtask

    task automatic push_req(input logic [31:0] a, input logic we, input logic chk_be,
                            input logic [3:0] be, input logic [31:0] wd, input logic [31:0] rd);
        req_t r;
        r.addr = a; r.we = we; r.chk_be = chk_be; r.be = be; r.wdata = wd; r.rdata = rd;
        req_q.push_back(r);
    endtask

    // Memory responder plus scoreboard monitor. Inputs are already driven
    // at the current negedge (cycle N).
    task automatic run_txn(input string name, input int wait_n,
                           input bit chk_hold, input logic [31:0] hold_val);
        bit          fin = 0;
        bit          d_seen = 0;
        logic        prev_req = 0, prev_ack = 0;
        int          cnt = 0;
        logic [31:0] cur_rdata = 32'h0;
        req_t        r;
        #1;
        vectors++;
        if (stall !== 1'b1 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL %s cycle N: stall=%b mem_req=%b, need stall=1 mem_req=0", name, stall, mem_req);
        end
        for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
            @(negedge clk);
            if (mem_req && !(prev_req && !prev_ack)) begin
                vectors++;
                if (req_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s issue: unexpected mem_req addr=%h", name, mem_addr);
                end else begin
                    r = req_q.pop_front();
                    cur_rdata = r.rdata;
                    if (mem_addr !== r.addr || mem_we !== r.we ||
                        (r.chk_be && mem_be !== r.be) || (r.we && mem_wdata !== r.wdata)) begin
                        miscompares++;
                        $display("FAIL %s issue: addr=%h we=%b be=%b wdata=%h, need addr=%h we=%b be=%b wdata=%h",
                                 name, mem_addr, mem_we, mem_be, mem_wdata, r.addr, r.we, r.be, r.wdata);
                    end
                end
            end
            if (mem_req && cnt == wait_n) begin
                mem_ack = 1; mem_rdata = cur_rdata; cnt = 0;
            end else begin
                mem_ack = 0; mem_rdata = 32'h0;
                if (mem_req) cnt++;
            end
            #1;
            if (d_done && d_read) begin
                vectors++;
                if (exp_d_q.size() == 0 || d_rdata !== exp_d_q[0]) begin
                    miscompares++;
                    $display("FAIL %s d_rdata: got %h, need %h", name, d_rdata,
                             exp_d_q.size() ? exp_d_q[0] : 32'hx);
                end
                if (exp_d_q.size() != 0) void'(exp_d_q.pop_front());
                d_seen = 1;
            end else if (chk_hold && d_seen) begin
                vectors++;
                if (d_rdata !== hold_val) begin
                    miscompares++;
                    $display("FAIL %s d_rdata hold: got %h, need %h", name, d_rdata, hold_val);
                end
            end
            if (if_done) begin
                vectors++;
                if (exp_if_q.size() == 0 || if_rdata !== exp_if_q[0]) begin
                    miscompares++;
                    $display("FAIL %s if_rdata: got %h, need %h", name, if_rdata,
                             exp_if_q.size() ? exp_if_q[0] : 32'hx);
                end
                if (exp_if_q.size() != 0) void'(exp_if_q.pop_front());
            end
            if (!stall) begin
                fin = 1;
                vectors++;
                if (req_q.size() || exp_d_q.size() || exp_if_q.size()) begin
                    miscompares++;
                    $display("FAIL %s stall: dropped with %0d/%0d/%0d outstanding, need 0/0/0",
                             name, req_q.size(), exp_d_q.size(), exp_if_q.size());
                end
            end
            prev_req = mem_req;
            prev_ack = mem_ack;
        end
        if (!fin) begin
            miscompares++;
            $display("FAIL %s timeout: stall=%b, need 0 within 40 cycles", name, stall);
        end
        req_q.delete(); exp_d_q.delete(); exp_if_q.delete();
        @(negedge clk);
        clear_inputs();
        mem_ack = 0;
        #1;
        vectors++;
        if (mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after done: mem_req=%b, need 0", name, mem_req);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        mem_ack = 0; mem_rdata = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        vectors++;
        if ({mem_req, mem_we, stall, if_done, d_done, d_misalign} !== 6'b0 ||
            mem_addr !== 0 || mem_wdata !== 0 || mem_be !== 4'b0000 ||
            d_rdata !== 0 || if_rdata !== 0) begin
            miscompares++;
            $display("FAIL reset: req=%b we=%b stall=%b addr=%h wd=%h be=%b drd=%h ird=%h, need all 0",
                     mem_req, mem_we, stall, mem_addr, mem_wdata, mem_be, d_rdata, if_rdata);
        end
    endtask

    task automatic test_fetch();
        @(negedge clk);
        if_req = 1; if_addr = 32'h0000_0010;
        push_req(32'h10, 0, 1, 4'b1111, 32'h0, 32'h0010_0093);
        exp_if_q.push_back(32'h0010_0093);
        run_txn("fetch", 0, 0, 32'h0);
    endtask

    task automatic do_load(input string name, input logic [31:0] a, input logic [1:0] sz,
                           input logic uns, input logic [31:0] rd, input logic [31:0] expv);
        @(negedge clk);
        d_read = 1; d_addr = a; d_size = sz; d_unsigned = uns;
        push_req(a & 32'hFFFF_FFFC, 0, 0, 4'b0, 32'h0, rd);
        exp_d_q.push_back(expv);
        run_txn(name, 1, 0, 32'h0);
    endtask

    task automatic test_loads();
        do_load("lb",  32'h103, 2'b00, 0, 32'h80AB_CDEF, 32'hFFFF_FF80);
        do_load("lbu", 32'h103, 2'b00, 1, 32'h80AB_CDEF, 32'h0000_0080);
        do_load("lh",  32'h102, 2'b01, 0, 32'h80AB_CDEF, 32'hFFFF_80AB);
        do_load("lhu", 32'h100, 2'b01, 1, 32'h80AB_CDEF, 32'h0000_CDEF);
        do_load("lb1", 32'h101, 2'b00, 0, 32'h80AB_CDEF, 32'hFFFF_FFCD);
        do_load("lw",  32'h104, 2'b10, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    endtask

    task automatic do_store(input string name, input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] wd, input logic [3:0] ebe, input logic [31:0] ewd);
        @(negedge clk);
        d_write = 1; d_addr = a; d_size = sz; d_wdata = wd;
        push_req(a & 32'hFFFF_FFFC, 1, 1, ebe, ewd, 32'h0);
        run_txn(name, 0, 0, 32'h0);
    endtask

    task automatic test_stores();
        do_store("sh",  32'h202, 2'b01, 32'h1234_5678, 4'b1100, 32'h5678_5678);
        do_store("sb",  32'h301, 2'b00, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB);
        do_store("sw",  32'h400, 2'b10, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
        do_store("s11", 32'h404, 2'b11, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        d_read = 1; d_addr = 32'h40; d_size = 2'b10;
        if_req = 1; if_addr = 32'h8;
        push_req(32'h40, 0, 0, 4'b0, 32'h0, 32'h1122_3344);
        push_req(32'h08, 0, 1, 4'b1111, 32'h0, 32'h0000_0013);
        exp_d_q.push_back(32'h1122_3344);
        exp_if_q.push_back(32'h0000_0013);
        run_txn("data+fetch", 2, 1, 32'h1122_3344);
    endtask

    task automatic do_misalign(input string name, input logic rd, input logic [31:0] a,
                               input logic [1:0] sz);
        @(negedge clk);
        d_read = rd; d_write = ~rd; d_addr = a; d_size = sz;
        #1;
        vectors++;
        if (d_misalign !== 1'b1 || d_done !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: misalign=%b done=%b stall=%b req=%b, need 1 1 0 0",
                     name, d_misalign, d_done, stall, mem_req);
        end
        @(negedge clk);
        clear_inputs();
        repeat (2) begin
            #1;
            vectors++;
            if (mem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL %s no access: mem_req=%b, need 0", name, mem_req);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_misalign();
        do_misalign("lw 0x42", 1, 32'h42, 2'b10);
        do_misalign("sh 0x101", 0, 32'h101, 2'b01);
    endtask

    task automatic test_reset_mid();
        bit got = 0;
        @(negedge clk);
        d_read = 1; d_addr = 32'h40; d_size = 2'b10;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clk);
            if (mem_req) got = 1;
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL reset_mid issue: mem_req=0, need 1");
        end
        #2;
        rst_n = 0;
        #1;
        vectors++;
        if (mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid drop: mem_req=%b, need 0", mem_req);
        end
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
        mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        #1;
        vectors++;
        if (d_done !== 1'b0 || if_done !== 1'b0 || mem_req !== 1'b0 || d_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid late ack: d_done=%b if_done=%b req=%b d_rdata=%h, need 0 0 0 0",
                     d_done, if_done, mem_req, d_rdata);
        end
        @(negedge clk);
        mem_ack = 0; mem_rdata = 0;
        if_req = 1; if_addr = 32'h20;
        push_req(32'h20, 0, 1, 4'b1111, 32'h0, 32'h0000_0073);
        exp_if_q.push_back(32'h0000_0073);
        run_txn("post-reset fetch", 0, 0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_loads();
        test_stores();
        test_back_to_back();
        test_misalign();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
